// File: rtl/spi_master_arb_if.sv
// Bundles the two requester handshakes, the tagged response and the SPI pins of spi_master_arb.
// The slave modport is the arbiter's view; the master modport is the host/board side.
interface spi_master_arb_if #(
   parameter int DATA_W = 8
);
   logic              req0_valid;
   logic [DATA_W-1:0] req0_data;
   logic              req0_ready;
   logic              req1_valid;
   logic [DATA_W-1:0] req1_data;
   logic              req1_ready;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_id;
   logic              busy;
   logic              o_sclk;
   logic              o_mosi;
   logic              o_ss;
   logic              i_miso;

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data, i_miso,
      output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, busy,
             o_sclk, o_mosi, o_ss
   );

   modport master (
      output req0_valid, req0_data, req1_valid, req1_data, i_miso,
      input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, busy,
             o_sclk, o_mosi, o_ss
   );
endinterface

// File: rtl/spi_master_arb.sv
// Mode-0 SPI master (MSB first, one byte per SS frame) shared by two requesters, round-robin.
// Define SPI_LOOPBACK_EN to shift o_mosi into the receiver instead of i_miso (bring-up self-test).
module spi_master_arb #(
   parameter int CLK_DIV = 4,
   parameter int DATA_W  = 8
) (
   input  logic            clk,
   input  logic            rst,
   spi_master_arb_if.slave bus
);
   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(DATA_W + 1);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_GAP} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  div_cnt_q, div_cnt_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic              last_grant_q, last_grant_d;
   logic              busy_q, busy_d;
   logic              ss_q, ss_d;
   logic              sclk_q, sclk_d;
   logic              mosi_q, mosi_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_id_q, rsp_id_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
   logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
   logic              tick;
   logic              grant;
   logic              winner;
   logic              rx_in;

`ifdef SPI_LOOPBACK_EN
   logic unused_miso;
   assign unused_miso = bus.i_miso;
   assign rx_in       = mosi_q;
`else
   assign rx_in       = bus.i_miso;
`endif

   assign tick   = (div_cnt_q == CNT_W'(CLK_DIV - 1));
   // A tie goes to whichever requester was not served last; reset makes req0 win first.
   assign winner = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;
   assign grant  = (state_q == S_IDLE) && (bus.req0_valid || bus.req1_valid) && !rst;

   assign bus.req0_ready = grant & ~winner;
   assign bus.req1_ready = grant &  winner;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_data   = rsp_data_q;
   assign bus.rsp_id     = rsp_id_q;
   assign bus.busy       = busy_q;
   assign bus.o_sclk     = sclk_q;
   assign bus.o_mosi     = mosi_q;
   assign bus.o_ss       = ss_q;

   always_comb begin
      state_d      = state_q;
      div_cnt_d    = tick ? '0 : div_cnt_q + 1'b1;
      bit_cnt_d    = bit_cnt_q;
      last_grant_d = last_grant_q;
      busy_d       = busy_q;
      ss_d         = ss_q;
      sclk_d       = sclk_q;
      mosi_d       = mosi_q;
      rsp_valid_d  = 1'b0;
      rsp_id_d     = rsp_id_q;
      rsp_data_d   = rsp_data_q;
      tx_sr_d      = tx_sr_q;
      rx_sr_d      = rx_sr_q;

      case (state_q)
         S_IDLE: begin
            div_cnt_d = '0;
            if (grant) begin
               tx_sr_d      = winner ? bus.req1_data : bus.req0_data;
               mosi_d       = tx_sr_d[DATA_W-1];
               rsp_id_d     = winner;
               last_grant_d = winner;
               busy_d       = 1'b1;
               ss_d         = 1'b0;
               bit_cnt_d    = '0;
               state_d      = S_SETUP;
            end
         end
         S_SETUP: begin
            if (tick) begin
               sclk_d  = 1'b1;
               rx_sr_d = {rx_sr_q[DATA_W-2:0], rx_in};
               state_d = S_XFER;
            end
         end
         // Ticks alternate between the end of a high phase (fall) and the end of a low phase.
         S_XFER: begin
            if (tick) begin
               if (sclk_q) begin
                  sclk_d    = 1'b0;
                  tx_sr_d   = tx_sr_q << 1;
                  mosi_d    = tx_sr_q[DATA_W-2];
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end else if (bit_cnt_q == BIT_W'(DATA_W)) begin
                  state_d = S_HOLD;
               end else begin
                  sclk_d  = 1'b1;
                  rx_sr_d = {rx_sr_q[DATA_W-2:0], rx_in};
               end
            end
         end
         S_HOLD: begin
            if (tick) begin
               ss_d        = 1'b1;
               rsp_valid_d = 1'b1;
               rsp_data_d  = rx_sr_q;
               state_d     = S_GAP;
            end
         end
         S_GAP: begin
            if (tick) begin
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         div_cnt_q    <= '0;
         bit_cnt_q    <= '0;
         last_grant_q <= 1'b1;
         busy_q       <= 1'b0;
         ss_q         <= 1'b1;
         sclk_q       <= 1'b0;
         mosi_q       <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= 1'b0;
         rsp_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         div_cnt_q    <= div_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         last_grant_q <= last_grant_d;
         busy_q       <= busy_d;
         ss_q         <= ss_d;
         sclk_q       <= sclk_d;
         mosi_q       <= mosi_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_data_q   <= rsp_data_d;
      end
   end

   // Shift registers are fully overwritten by every frame, so they carry no reset.
   always_ff @(posedge clk) begin
      tx_sr_q <= tx_sr_d;
      rx_sr_q <= rx_sr_d;
   end
endmodule
